ifetch_queue: RTL
=================

Name: ifetch_queue

Overview:
- Parametrised instruction prefetch unit that replaces the single-register, ihit-gated PC update with a decoupled fetch stage.
- Issues instruction-memory reads on the datapath_cache_if instruction side and buffers fetched words with their PCs in a DEPTH-entry FIFO.
- Presents the oldest entry to decode, and supports redirect (branch/jump flush) and a sticky halt stop.
- Sits between the program counter logic and control-unit decode in the pipelined datapath.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
ADDR_W, 32, fetch address width; instruction word is fixed at 32 bits
PC_INIT, 0, fetch address loaded at reset

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  synchronous active-low reset
imemREN  output  1  instruction read request to cache
imemaddr  output  ADDR_W  address of the outstanding request
imemload  input  32  instruction word, valid when ihit
ihit  input  1  cache completed the current request this cycle
deq  input  1  decode consumes the head entry this cycle
redirect  input  1  flush queue and restart fetch at redirect_pc
redirect_pc  input  ADDR_W  new fetch address
instr_valid  output  1  head entry (instr, instr_pc) is valid
instr  output  32  head instruction word
instr_pc  output  ADDR_W  PC of head instruction
instr_npc  output  ADDR_W  instr_pc + 4, used for JAL link
count  output  $clog2(DEPTH)+1  occupied entries
halt  output  1  sticky: a HALT instruction has been dequeued

Behaviour:
- One clock (CLK); reset is synchronous and active-low on nRST. All state updates occur on the rising edge of CLK.
- Reset: when nRST is 0 at a rising edge:
  - fetch_pc <= PC_INIT; rd_ptr, wr_ptr, count <= 0; state <= FETCH; halt <= 0.
  - Outputs after reset: imemREN=1, imemaddr=PC_INIT, instr_valid=0, count=0, halt=0.
  - Reset mid-request abandons the request; an ihit arriving in the reset cycle is discarded.
- States: FETCH (issuing requests) and STOPPED (halt seen). STOPPED is exited only by reset.
- imemREN = (state==FETCH) && (count<DEPTH) && !redirect. It is purely from registered state plus redirect; deq never feeds it.
- imemaddr = fetch_pc at all times. It is held stable until ihit or redirect.
- Push: on imemREN && ihit, write {imemload, fetch_pc} at wr_ptr; wr_ptr++ (mod DEPTH); fetch_pc <= fetch_pc+4 (wraps mod 2^ADDR_W). ihit while imemREN=0 is ignored.
- Pop: on deq && count>0, rd_ptr++ (mod DEPTH). deq when count==0 is ignored.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full (count==DEPTH): imemREN drops. A pop in that cycle re-enables imemREN on the next cycle; the one-bubble cost is intentional.
- instr_valid = (count!=0) && (state==FETCH). instr and instr_pc come from the entry at rd_ptr; instr_npc = instr_pc+4 (mod 2^ADDR_W).
- Redirect (highest priority):
  - rd_ptr=wr_ptr=count <= 0; fetch_pc <= {redirect_pc[ADDR_W-1:2],2'b00} (misaligned bits forced to zero).
  - ihit and deq in the same cycle are ignored.
  - Fetch resumes the next cycle.
  - In STOPPED, redirect is ignored.
- Halt: on a pop (deq accepted, no redirect) whose instr[31:26]==6'b111111 (HALT opcode):
  - state <= STOPPED, halt <= 1, and the queue is flushed.
  - The HALT entry itself is considered consumed.
  - In STOPPED: imemREN=0, instr_valid=0, and deq and ihit are ignored.

Optional Feature:
IFQ_BYPASS_EN
- Defined: when count==0, state==FETCH, imemREN && ihit, the incoming word is presented combinationally on instr/instr_pc with instr_valid=1 in the same cycle.
  - If deq is also asserted, the word is consumed without being written (count stays 0); otherwise it is pushed normally.
  - Halt and redirect rules apply unchanged to the bypassed entry.
- Undefined: minimum fetch-to-decode latency is one cycle; instr_valid is purely registered.

Test Plan:
- Reset with PC_INIT=0, ihit=1 every cycle, deq=0 -> imemaddr 0,4,8,12; count reaches 4 after 4 cycles; imemREN=0 thereafter; head instr_pc=0, instr_npc=4.
- Queue full (DEPTH=4), pulse deq one cycle -> count 3; imemREN=1 the following cycle at imemaddr=16; next ihit restores count 4.
- Queue holding 3 entries, redirect=1 with redirect_pc=0x00000103, ihit=1, deq=1 -> next cycle count=0, instr_valid=0, imemaddr=0x00000100; the ihit data is not enqueued.
- Enqueue words 0x00000000, 0xFC000000 (HALT), 0x20010001; deq twice -> after the second deq halt=1, imemREN=0, instr_valid=0, count=0; later redirect has no effect.
- fetch_pc=2^ADDR_W-4, ihit -> entry instr_pc=0xFFFFFFFC, instr_npc=0, next imemaddr=0.
- Drive nRST=0 for one edge with count=2 and an outstanding request -> count=0, imemaddr=PC_INIT, halt=0.
- With IFQ_BYPASS_EN: empty queue, ihit with imemload=0x8C220004 and deq=1 in the same cycle -> instr_valid=1 and instr=0x8C220004 that cycle; count remains 0.

Source files
------------

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_queue
//  Brief    : Decoupled instruction prefetch unit. Issues instruction-memory
//             reads and holds each fetched word and its PC in a DEPTH-entry
//             FIFO. Decode reads the oldest entry. Branch/jump redirect
//             flushes the FIFO. Dequeuing a HALT stops fetch until reset.
//  Options  : IFQ_BYPASS_EN - when defined, a word that arrives while the
//             queue is empty is shown to decode in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module ifetch_queue #(
    parameter int                 DEPTH   = 4,
    parameter int                 ADDR_W  = 32,
    parameter logic [ADDR_W-1:0]  PC_INIT = '0
) (
    input  logic                        CLK,
    input  logic                        nRST,
    output logic                        imemREN,
    output logic [ADDR_W-1:0]           imemaddr,
    input  logic [31:0]                 imemload,
    input  logic                        ihit,
    input  logic                        deq,
    input  logic                        redirect,
    input  logic [ADDR_W-1:0]           redirect_pc,
    output logic                        instr_valid,
    output logic [31:0]                 instr,
    output logic [ADDR_W-1:0]           instr_pc,
    output logic [ADDR_W-1:0]           instr_npc,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        halt
);

    localparam int         PTR_W       = $clog2(DEPTH);
    localparam int         CNT_W       = PTR_W + 1;
    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    typedef enum logic [0:0] {
        FETCH   = 1'b0,
        STOPPED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               halt_q, halt_d;

    logic [31:0]        mem_instr_q [DEPTH];
    logic [ADDR_W-1:0]  mem_pc_q    [DEPTH];

    logic               is_fetch;
    logic               push;
    logic               bypass;
    logic               pop;
    logic               pop_mem;
    logic               halt_pop;
    logic               mem_we;

    // The two low bits of redirect_pc are always forced to zero.
    logic               unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Request, head-of-queue presentation and pop/push qualification
    always_comb begin
        is_fetch = (state_q == FETCH);
        imemREN  = is_fetch && (count_q < CNT_W'(DEPTH)) && !redirect;
        imemaddr = fetch_pc_q;
        push     = imemREN && ihit;
`ifdef IFQ_BYPASS_EN
        bypass   = push && (count_q == '0);
`else
        bypass   = 1'b0;
`endif
        instr       = bypass ? imemload   : mem_instr_q[rd_ptr_q];
        instr_pc    = bypass ? fetch_pc_q : mem_pc_q[rd_ptr_q];
        instr_valid = is_fetch && ((count_q != '0) || bypass);
        instr_npc   = instr_pc + ADDR_W'(4);
        pop         = deq && instr_valid && !redirect;
        halt_pop    = pop && (instr[31:26] == HALT_OPCODE);
        // A bypassed word that decode takes right away never touches storage.
        pop_mem     = pop && !bypass;
        mem_we      = push && !halt_pop && !(bypass && pop);
        count       = count_q;
        halt        = halt_q;
    end

    // Next-state: redirect beats halt, halt beats normal push/pop
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        halt_d     = halt_q;
        if (is_fetch) begin
            if (redirect) begin
                rd_ptr_d   = '0;
                wr_ptr_d   = '0;
                count_d    = '0;
                fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
            end else if (halt_pop) begin
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                count_d  = '0;
                state_d  = STOPPED;
                halt_d   = 1'b1;
            end else begin
                if (push) begin
                    fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                end
                if (mem_we) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                if (pop_mem) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                case ({mem_we, pop_mem})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    // Control state registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q    <= FETCH;
            fetch_pc_q <= PC_INIT;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            halt_q     <= halt_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers gate them
    always_ff @(posedge CLK) begin
        if (nRST && mem_we) begin
            mem_instr_q[wr_ptr_q] <= imemload;
            mem_pc_q[wr_ptr_q]    <= fetch_pc_q;
        end
    end

endmodule
`default_nettype wire
